// File: rtl/object_spawner_pkg.sv
// Shared types and constants for the falling-object spawner.
// Every coordinate and the LFSR state are the same 11-bit unsigned width.
package object_spawner_pkg;

    localparam int WIDTH = 11;

    // Feedback taps for x^11 + x^9 + 1
    localparam int LFSR_TAP_HI = 10;
    localparam int LFSR_TAP_LO = 8;

    localparam logic [WIDTH-1:0] DEFAULT_LFSR_SEED = 11'h001;

    typedef logic [WIDTH-1:0] coord_t;

endpackage

// File: rtl/object_spawner_lfsr.sv
// Free-running 11-bit Fibonacci LFSR (period 2047, never all-zero).
// The seed must be nonzero or the register locks up at zero.
module object_spawner_lfsr
    import object_spawner_pkg::*;
#(
    parameter coord_t SEED = DEFAULT_LFSR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= SEED;
        end else begin
            out <= {out[WIDTH-2:0], out[LFSR_TAP_HI] ^ out[LFSR_TAP_LO]};
        end
    end

endmodule

// File: rtl/object_spawner.sv
// Falling game object: steps down one row every STEP_DIV clocks and respawns
// at the top in a pseudo-random column once it passes the bottom row.
module object_spawner
    import object_spawner_pkg::*;
#(
    parameter int     STEP_DIV  = 4,
    parameter int     X_MAX     = 639,
    parameter int     Y_MAX     = 479,
    parameter coord_t LFSR_SEED = DEFAULT_LFSR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] random_number,
    output logic [WIDTH-1:0] object_position,
    output logic [WIDTH-1:0] object_row,
    output logic             respawn
);

    localparam int               CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam coord_t           X_LIMIT  = coord_t'(X_MAX);
    localparam coord_t           X_SPAN   = coord_t'(X_MAX + 1);
    localparam coord_t           Y_LIMIT  = coord_t'(Y_MAX);

    // X_SPAN >= 512, so three subtractions bring any 11-bit value into range.
    function automatic coord_t reduce(input coord_t r);
        coord_t v;
        v = r;
        for (int i = 0; i < 3; i++) begin
            if (v > X_LIMIT) begin
                v = v - X_SPAN;
            end
        end
        return v;
    endfunction

    logic [CNT_W-1:0] step_cnt;
    logic             step;

    object_spawner_lfsr #(
        .SEED (LFSR_SEED)
    ) lfsr (
        .clk  (clk),
        .rst  (rst),
        .out  (random_number)
    );

    assign step = (step_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (step) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + CNT_W'(1);
        end
    end

    // The column is taken from the LFSR value visible before the respawn edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            object_row      <= '0;
            object_position <= '0;
            respawn         <= 1'b0;
        end else begin
            respawn <= 1'b0;
            if (step) begin
                if (object_row < Y_LIMIT) begin
                    object_row <= object_row + coord_t'(1);
                end else begin
                    object_row      <= '0;
                    object_position <= reduce(random_number);
                    respawn         <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_object_spawner.sv
// Scoreboard bench for object_spawner: a cycle model pushes expected outputs
// before each clock edge; they are popped and compared on the following falling edge.
module tb_object_spawner;

    localparam int STEP_DIV = 4;
    localparam int X_MAX    = 639;
    localparam int Y_MAX    = 479;

    typedef struct packed {
        logic [10:0] lfsr;
        logic [10:0] pos;
        logic [10:0] row;
        logic        resp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [10:0] random_number;
    logic [10:0] object_position;
    logic [10:0] object_row;
    logic        respawn;
    logic [10:0] rn_f;
    logic [10:0] pos_f;
    logic [10:0] row_f;
    logic        resp_f;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t        sbq[$];
    logic [10:0] fq[$];

    logic [10:0] m_lfsr;
    logic [10:0] m_row;
    logic [10:0] m_pos;
    logic        m_resp;
    int          m_cnt;

    logic [10:0] lfsr_tbl [12] = '{11'd1, 11'd2, 11'd4, 11'd8, 11'd16, 11'd32,
                                   11'd64, 11'd128, 11'd256, 11'd513, 11'd1026, 11'd5};

    object_spawner #(
        .STEP_DIV  (STEP_DIV),
        .X_MAX     (X_MAX),
        .Y_MAX     (Y_MAX),
        .LFSR_SEED (11'h001)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .random_number   (random_number),
        .object_position (object_position),
        .object_row      (object_row),
        .respawn         (respawn)
    );

    // Respawns on every edge, exposing reduce() to every LFSR value.
    object_spawner #(
        .STEP_DIV  (1),
        .X_MAX     (X_MAX),
        .Y_MAX     (0),
        .LFSR_SEED (11'h001)
    ) dut_fast (
        .clk             (clk),
        .rst             (rst),
        .random_number   (rn_f),
        .object_position (pos_f),
        .object_row      (row_f),
        .respawn         (resp_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] lfsr_next(input logic [10:0] q);
        return {q[9:0], q[10] ^ q[8]};
    endfunction

    function automatic logic [10:0] model_reduce(input logic [10:0] r);
        logic [10:0] v;
        v = r;
        repeat (3) begin
            if (v > 11'(X_MAX)) v = v - 11'(X_MAX + 1);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_lfsr = 11'd1;
        m_row  = '0;
        m_pos  = '0;
        m_resp = 1'b0;
        m_cnt  = 0;
        sbq.delete();
        fq.delete();
    endtask

    task automatic model_tick();
        exp_t e;
        m_resp = 1'b0;
        if (m_cnt == STEP_DIV - 1) begin
            m_cnt = 0;
            if (m_row == 11'(Y_MAX)) begin
                m_row  = '0;
                m_pos  = model_reduce(m_lfsr);
                m_resp = 1'b1;
            end else begin
                m_row = m_row + 11'd1;
            end
        end else begin
            m_cnt++;
        end
        m_lfsr = lfsr_next(m_lfsr);
        e.lfsr = m_lfsr;
        e.pos  = m_pos;
        e.row  = m_row;
        e.resp = m_resp;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #10;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        #1;
        n_cmp += 4;
        if (random_number !== 11'd1) begin n_fail++; $display("FAIL reset_async lfsr got=%0d exp=1", random_number); end
        if (object_position !== 11'd0) begin n_fail++; $display("FAIL reset_async pos got=%0d exp=0", object_position); end
        if (object_row !== 11'd0) begin n_fail++; $display("FAIL reset_async row got=%0d exp=0", object_row); end
        if (respawn !== 1'b0) begin n_fail++; $display("FAIL reset_async respawn got=%0b exp=0", respawn); end
        @(posedge clk);
        @(negedge clk);
        n_cmp += 2;
        if (random_number !== 11'd1) begin n_fail++; $display("FAIL reset_hold lfsr got=%0d exp=1", random_number); end
        if (object_row !== 11'd0) begin n_fail++; $display("FAIL reset_hold row got=%0d exp=0", object_row); end
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 5; k++) begin
            model_tick();
            @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp += 2;
            if (random_number !== e.lfsr) begin n_fail++; $display("FAIL reset_run lfsr cyc=%0d got=%0d exp=%0d", k, random_number, e.lfsr); end
            if (object_row !== e.row) begin n_fail++; $display("FAIL reset_run row cyc=%0d got=%0d exp=%0d", k, object_row, e.row); end
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp += 4;
        if (random_number !== 11'd1) begin n_fail++; $display("FAIL reset_mid_cycle lfsr got=%0d exp=1", random_number); end
        if (object_position !== 11'd0) begin n_fail++; $display("FAIL reset_mid_cycle pos got=%0d exp=0", object_position); end
        if (object_row !== 11'd0) begin n_fail++; $display("FAIL reset_mid_cycle row got=%0d exp=0", object_row); end
        if (respawn !== 1'b0) begin n_fail++; $display("FAIL reset_mid_cycle respawn got=%0b exp=0", respawn); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_lfsr();
        exp_t e;
        do_reset();
        n_cmp++;
        if (random_number !== lfsr_tbl[0]) begin n_fail++; $display("FAIL lfsr_seq cyc=0 got=%0d exp=%0d", random_number, lfsr_tbl[0]); end
        for (int k = 1; k <= 4094; k++) begin
            model_tick();
            @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp += 6;
            if (random_number !== e.lfsr) begin n_fail++; $display("FAIL lfsr_model cyc=%0d got=%0d exp=%0d", k, random_number, e.lfsr); end
            if (random_number === 11'd0) begin n_fail++; $display("FAIL lfsr_zero cyc=%0d got=0 exp=nonzero", k); end
            if ((random_number === 11'd1) != (k % 2047 == 0)) begin
                n_fail++;
                $display("FAIL lfsr_period cyc=%0d got=%0d seed_expected=%0b", k, random_number, (k % 2047 == 0));
            end
            if (object_row !== e.row) begin n_fail++; $display("FAIL lfsr_run row cyc=%0d got=%0d exp=%0d", k, object_row, e.row); end
            if (object_position !== e.pos) begin n_fail++; $display("FAIL lfsr_run pos cyc=%0d got=%0d exp=%0d", k, object_position, e.pos); end
            if (respawn !== e.resp) begin n_fail++; $display("FAIL lfsr_run respawn cyc=%0d got=%0b exp=%0b", k, respawn, e.resp); end
            if (k < 12) begin
                n_cmp++;
                if (random_number !== lfsr_tbl[k]) begin n_fail++; $display("FAIL lfsr_seq cyc=%0d got=%0d exp=%0d", k, random_number, lfsr_tbl[k]); end
            end
        end
    endtask

    task automatic test_stepping();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            model_tick();
            @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp += 4;
            if (object_row !== 11'(k / 4)) begin n_fail++; $display("FAIL step_row edge=%0d got=%0d exp=%0d", k, object_row, k / 4); end
            if (object_row !== e.row) begin n_fail++; $display("FAIL step_row_model edge=%0d got=%0d exp=%0d", k, object_row, e.row); end
            if (object_position !== 11'd0) begin n_fail++; $display("FAIL step_pos edge=%0d got=%0d exp=0", k, object_position); end
            if (respawn !== 1'b0) begin n_fail++; $display("FAIL step_respawn edge=%0d got=%0b exp=0", k, respawn); end
        end
    endtask

    task automatic test_respawn();
        exp_t e;
        int   resp_cnt;
        resp_cnt = 0;
        do_reset();
        for (int k = 1; k <= 1921; k++) begin
            model_tick();
            @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            if (respawn === 1'b1) resp_cnt++;
            n_cmp += 4;
            if (random_number !== e.lfsr) begin n_fail++; $display("FAIL respawn_run lfsr cyc=%0d got=%0d exp=%0d", k, random_number, e.lfsr); end
            if (object_row !== e.row) begin n_fail++; $display("FAIL respawn_run row cyc=%0d got=%0d exp=%0d", k, object_row, e.row); end
            if (object_position !== e.pos) begin n_fail++; $display("FAIL respawn_run pos cyc=%0d got=%0d exp=%0d", k, object_position, e.pos); end
            if (respawn !== e.resp) begin n_fail++; $display("FAIL respawn_run respawn cyc=%0d got=%0b exp=%0b", k, respawn, e.resp); end
            if (k == 1916) begin
                n_cmp++;
                if (object_row !== 11'd479) begin n_fail++; $display("FAIL respawn_bottom row got=%0d exp=479", object_row); end
            end
            if (k == 1920) begin
                n_cmp += 3;
                if (respawn !== 1'b1) begin n_fail++; $display("FAIL respawn_pulse got=%0b exp=1", respawn); end
                if (object_row !== 11'd0) begin n_fail++; $display("FAIL respawn_wrap row got=%0d exp=0", object_row); end
                if (object_position > 11'(X_MAX)) begin n_fail++; $display("FAIL respawn_range pos got=%0d exp<=%0d", object_position, X_MAX); end
            end
        end
        n_cmp++;
        if (resp_cnt != 1) begin n_fail++; $display("FAIL respawn_count got=%0d exp=1", resp_cnt); end
    endtask

    task automatic test_reset_mid_fall();
        exp_t e;
        int   k;
        do_reset();
        k = 0;
        while (m_row != 11'd200 && k < 2000) begin
            model_tick();
            @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            k++;
        end
        n_cmp++;
        if (object_row !== 11'd200) begin n_fail++; $display("FAIL midfall_reach row got=%0d exp=200", object_row); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp += 4;
        if (random_number !== 11'd1) begin n_fail++; $display("FAIL midfall_reset lfsr got=%0d exp=1", random_number); end
        if (object_position !== 11'd0) begin n_fail++; $display("FAIL midfall_reset pos got=%0d exp=0", object_position); end
        if (object_row !== 11'd0) begin n_fail++; $display("FAIL midfall_reset row got=%0d exp=0", object_row); end
        if (respawn !== 1'b0) begin n_fail++; $display("FAIL midfall_reset respawn got=%0b exp=0", respawn); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int j = 1; j <= 8; j++) begin
            model_tick();
            @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp += 3;
            if (object_row !== 11'(j / 4)) begin n_fail++; $display("FAIL midfall_row edge=%0d got=%0d exp=%0d", j, object_row, j / 4); end
            if (object_position !== 11'd0) begin n_fail++; $display("FAIL midfall_pos edge=%0d got=%0d exp=0", j, object_position); end
            if (random_number !== lfsr_tbl[j]) begin n_fail++; $display("FAIL midfall_lfsr edge=%0d got=%0d exp=%0d", j, random_number, lfsr_tbl[j]); end
        end
    endtask

    task automatic test_reduce();
        logic [10:0] f;
        logic [10:0] ep;
        logic [10:0] r;
        for (int i = 0; i < 2048; i++) begin
            r = 11'(i);
            n_cmp++;
            if (model_reduce(r) !== 11'(i % (X_MAX + 1))) begin
                n_fail++;
                $display("FAIL reduce_model r=%0d got=%0d exp=%0d", i, model_reduce(r), i % (X_MAX + 1));
            end
        end
        do_reset();
        f = 11'd1;
        for (int k = 1; k <= 2047; k++) begin
            fq.push_back(11'(int'(f) % (X_MAX + 1)));
            f = lfsr_next(f);
            @(posedge clk);
            @(negedge clk);
            ep = fq.pop_front();
            n_cmp += 4;
            if (pos_f !== ep) begin n_fail++; $display("FAIL reduce_dut cyc=%0d got=%0d exp=%0d", k, pos_f, ep); end
            if (resp_f !== 1'b1) begin n_fail++; $display("FAIL reduce_respawn cyc=%0d got=%0b exp=1", k, resp_f); end
            if (row_f !== 11'd0) begin n_fail++; $display("FAIL reduce_row cyc=%0d got=%0d exp=0", k, row_f); end
            if (rn_f !== f) begin n_fail++; $display("FAIL reduce_lfsr cyc=%0d got=%0d exp=%0d", k, rn_f, f); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_lfsr();
        test_stepping();
        test_respawn();
        test_reset_mid_fall();
        test_reduce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
